// File: rtl/thrm_pkg.sv
// thrm_pkg -- shared constants and types for the thermometer decoder.
//   MTRX_W / BAND_W     : field widths of the matrix and band thermometers
//   *_LSB               : bit offsets of the four matrix fields in the 64-bit word
//   mtrx_t              : packed view of the 64-bit matrix word
package thrm_pkg;

    localparam int MTRX_W      = 16;
    localparam int BAND_W      = 32;
    localparam int COL_ON_LSB  = 0;
    localparam int COL_OFF_LSB = 16;
    localparam int ROW_P_LSB   = 32;
    localparam int ROW_N_LSB   = 48;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Packed MSB-first, so row_n lands on [63:48] and col_on on [15:0].
    typedef struct packed {
        logic [MTRX_W-1:0] row_n;
        logic [MTRX_W-1:0] row_p;
        logic [MTRX_W-1:0] col_off;
        logic [MTRX_W-1:0] col_on;
    } mtrx_t;

endpackage

// File: rtl/thrm_chk.sv
// thrm_chk -- popcount and thermometer-legality check for one field.
//   thrm  in  W                 : LSB-filled thermometer code
//   cnt   out $clog2(W+1)       : number of set bits
//   legal out 1                 : 1 when exactly bits [cnt-1:0] are set
module thrm_chk #(
    parameter int W = 16
) (
    input  logic [W-1:0]               thrm,
    output logic [$clog2(W+1)-1:0]     cnt,
    output logic                       legal
);

    localparam int CW = $clog2(W+1);

    logic [W-1:0] mask;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + CW'(thrm[i]);
        end
    end

    // Shifting all-ones left by cnt leaves the bits that must be clear;
    // a shift by the full width yields zero, which covers the all-ones code.
    always_comb begin
        mask  = {W{1'b1}} << cnt;
        legal = (thrm == ~mask);
    end

endmodule

// File: rtl/thrm_dec.sv
// thrm_dec -- two-stage decoder for a capacitor-matrix thermometer and a band
// thermometer, with illegal-code detection and error accounting.
//   dec_clk, dec_rst        : clock, synchronous active-high reset
//   csr_dec_en              : 0 freezes captures and drops in-flight valids
//   in_vld, mtrx_thrm,
//   band_thrm               : input word (row_n|row_p|col_off|col_on) and band code
//   err_clr                 : clears err_sticky and err_cnt
//   out_vld, num_cap,
//   num_band, code_err      : decoded result, valid two cycles after acceptance
//   out_chg                 : pulse when a valid result differs from the last one
//   err_sticky, err_cnt     : error flag and saturating error counter
// Build option: define THRM_DEC_ERR_CNT_EN to include the error counter;
// without it err_cnt is constant zero.
module thrm_dec
    import thrm_pkg::*;
(
    input  logic                    dec_clk,
    input  logic                    dec_rst,
    input  logic                    csr_dec_en,
    input  logic                    in_vld,
    input  logic [4*MTRX_W-1:0]     mtrx_thrm,
    input  logic [BAND_W-1:0]       band_thrm,
    input  logic                    err_clr,
    output logic                    out_vld,
    output logic [7:0]              num_cap,
    output logic [$clog2(BAND_W+1)-1:0] num_band,
    output logic                    code_err,
    output logic                    out_chg,
    output logic                    err_sticky,
    output logic [7:0]              err_cnt
);

    localparam int MCW = $clog2(MTRX_W+1);
    localparam int BCW = $clog2(BAND_W+1);

    logic              s1_vld;
    mtrx_t             s1_mtrx;
    logic [BAND_W-1:0] s1_band;

    always_ff @(posedge dec_clk) begin
        if (dec_rst) begin
            s1_vld  <= 1'b0;
            s1_mtrx <= '0;
            s1_band <= '0;
        end else begin
            s1_vld <= csr_dec_en & in_vld;
            if (csr_dec_en && in_vld) begin
                s1_mtrx <= mtrx_t'(mtrx_thrm);
                s1_band <= band_thrm;
            end
        end
    end

    logic [MCW-1:0] row_cnt, col_cnt;
    logic [BCW-1:0] band_cnt;
    logic           row_legal, col_legal, band_legal;

    thrm_chk #(.W(MTRX_W)) u_chk_row (
        .thrm  (s1_mtrx.row_p),
        .cnt   (row_cnt),
        .legal (row_legal)
    );

    thrm_chk #(.W(MTRX_W)) u_chk_col (
        .thrm  (s1_mtrx.col_on),
        .cnt   (col_cnt),
        .legal (col_legal)
    );

    thrm_chk #(.W(BAND_W)) u_chk_band (
        .thrm  (s1_band),
        .cnt   (band_cnt),
        .legal (band_legal)
    );

    logic [8:0] cap_sum;
    logic [7:0] cap_sat;
    logic       dec_err;

    // Popcounts are used even for bubbled codes so a single flipped bit
    // shifts the count by one instead of truncating it.
    always_comb begin
        cap_sum = {row_cnt, 4'b0000} + 9'(col_cnt);
        cap_sat = cap_sum[8] ? 8'hFF : cap_sum[7:0];
        dec_err = !row_legal || !col_legal || !band_legal
                  || (s1_mtrx.row_n   != ~s1_mtrx.row_p)
                  || (s1_mtrx.col_off != ~s1_mtrx.col_on)
                  || (&s1_mtrx.row_p);
    end

    logic s2_load;
    logic no_prev;
    logic err_hit;

    assign s2_load = csr_dec_en & s1_vld;
    assign err_hit = out_vld & code_err;

    // The data outputs hold the last valid result, so they double as the
    // previous-value register for change detection.
    always_ff @(posedge dec_clk) begin
        if (dec_rst) begin
            out_vld    <= 1'b0;
            num_cap    <= '0;
            num_band   <= '0;
            code_err   <= 1'b0;
            out_chg    <= 1'b0;
            no_prev    <= 1'b1;
            err_sticky <= 1'b0;
        end else begin
            out_vld <= s2_load;
            out_chg <= 1'b0;
            if (s2_load) begin
                num_cap  <= cap_sat;
                num_band <= band_cnt;
                code_err <= dec_err;
                out_chg  <= no_prev || (cap_sat != num_cap) || (band_cnt != num_band);
                no_prev  <= 1'b0;
            end
            if (err_hit) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

`ifdef THRM_DEC_ERR_CNT_EN
    always_ff @(posedge dec_clk) begin
        if (dec_rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= {7'b0, err_hit};
        end else if (err_hit && err_cnt != ERR_CNT_MAX) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_thrm_dec.sv
// tb_thrm_dec -- self-checking bench for thrm_dec: directed cases plus
// randomized traffic, compared every cycle against a behavioural model.
module tb_thrm_dec;

    logic        dec_clk = 1'b0;
    logic        dec_rst, csr_dec_en, in_vld, err_clr;
    logic [63:0] mtrx_thrm;
    logic [31:0] band_thrm;
    logic        out_vld, code_err, out_chg, err_sticky;
    logic [7:0]  num_cap, err_cnt;
    logic [5:0]  num_band;

    thrm_dec dut (
        .dec_clk    (dec_clk),
        .dec_rst    (dec_rst),
        .csr_dec_en (csr_dec_en),
        .in_vld     (in_vld),
        .mtrx_thrm  (mtrx_thrm),
        .band_thrm  (band_thrm),
        .err_clr    (err_clr),
        .out_vld    (out_vld),
        .num_cap    (num_cap),
        .num_band   (num_band),
        .code_err   (code_err),
        .out_chg    (out_chg),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    always #5 dec_clk = ~dec_clk;

`ifdef THRM_DEC_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    // Expected outputs, and the result accepted one edge earlier that will
    // retire at the next edge.
    bit m_vld, m_err, m_chg, m_sticky, m_seen;
    int m_cap, m_band, m_cnt;
    bit p_acc, p_err;
    int p_cap, p_band;

    function automatic int pop(input logic [63:0] x);
        int n = 0;
        for (int i = 0; i < 64; i++) n += int'(x[i]);
        return n;
    endfunction

    function automatic bit is_thrm(input logic [63:0] x);
        return (x & (x + 64'd1)) == 64'd0;
    endfunction

    function automatic void decode(input logic [63:0] m, input logic [31:0] b,
                                   output int cap, output int band, output bit err);
        logic [15:0] co, cf, rp, rn;
        co = m[15:0]; cf = m[31:16]; rp = m[47:32]; rn = m[63:48];
        cap  = 16 * pop({48'd0, rp}) + pop({48'd0, co});
        if (cap > 255) cap = 255;
        band = pop({32'd0, b});
        err  = !is_thrm({48'd0, rp}) || !is_thrm({48'd0, co}) || !is_thrm({32'd0, b})
               || (rn != ~rp) || (cf != ~co) || (rp == 16'hFFFF);
    endfunction

    function automatic logic [63:0] legal_m(input int s);
        logic [15:0] rp, co;
        rp = 16'((32'd1 << (s / 16)) - 32'd1);
        co = 16'((32'd1 << (s % 16)) - 32'd1);
        return {~rp, rp, ~co, co};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit hit;
        if (dec_rst) begin
            m_vld = 0; m_err = 0; m_chg = 0; m_sticky = 0; m_seen = 0;
            m_cap = 0; m_band = 0; m_cnt = 0; p_acc = 0;
        end else begin
            // Error accounting reacts to the result shown before this edge.
            hit = m_vld && m_err;
            if (hit) m_sticky = 1;
            else if (err_clr) m_sticky = 0;
            if (CNT_ON) begin
                if (err_clr) m_cnt = hit ? 1 : 0;
                else if (hit && m_cnt < 255) m_cnt++;
            end
            m_vld = csr_dec_en && p_acc;
            m_chg = 0;
            if (m_vld) begin
                m_chg  = !m_seen || (p_cap != m_cap) || (p_band != m_band);
                m_cap  = p_cap;
                m_band = p_band;
                m_err  = p_err;
                m_seen = 1;
            end
            p_acc = csr_dec_en && in_vld;
            if (p_acc) decode(mtrx_thrm, band_thrm, p_cap, p_band, p_err);
        end
    endtask

    // One clock: the model consumes the inputs sampled at the edge, then all
    // outputs are compared 1 time unit later.
    task automatic step();
        @(posedge dec_clk);
        model_edge();
        #1;
        check("out_vld",    int'(out_vld),    int'(m_vld));
        check("num_cap",    int'(num_cap),    m_cap);
        check("num_band",   int'(num_band),   m_band);
        check("code_err",   int'(code_err),   int'(m_err));
        check("out_chg",    int'(out_chg),    int'(m_chg));
        check("err_sticky", int'(err_sticky), int'(m_sticky));
        check("err_cnt",    int'(err_cnt),    m_cnt);
    endtask

    task automatic drive(input logic [63:0] m, input logic [31:0] b);
        in_vld = 1'b1; mtrx_thrm = m; band_thrm = b;
        step();
    endtask

    initial begin
        int nv, nc;
        logic [95:0] word;

        dec_rst = 1; csr_dec_en = 0; in_vld = 0; err_clr = 0;
        mtrx_thrm = '0; band_thrm = '0;
        m_vld = 0; m_err = 0; m_chg = 0; m_sticky = 0; m_seen = 0;
        m_cap = 0; m_band = 0; m_cnt = 0; p_acc = 0; p_err = 0; p_cap = 0; p_band = 0;
        step(); step();
        check("rst_vld", int'(out_vld), 0);
        check("rst_cap", int'(num_cap), 0);
        check("rst_sticky", int'(err_sticky), 0);
        dec_rst = 0; csr_dec_en = 1;

        // Legal sweep of every matrix count.
        for (int s = 0; s < 256; s++) begin
            drive(legal_m(s), 32'h3FF);
            if (s >= 1) begin
                check("sweep_vld",  int'(out_vld),  1);
                check("sweep_cap",  int'(num_cap),  s - 1);
                check("sweep_band", int'(num_band), 10);
                check("sweep_err",  int'(code_err), 0);
            end
        end
        in_vld = 0;
        step();
        check("sweep_last", int'(num_cap), 255);
        step();
        check("sweep_idle", int'(out_vld), 0);

        // Bubble in col_on.
        drive({16'hFFFF, 16'h0000, ~16'h0005, 16'h0005}, 32'h0);
        in_vld = 0;
        step();
        check("bubble_err", int'(code_err), 1);
        check("bubble_cap", int'(num_cap), 2);
        step();
        check("bubble_sticky", int'(err_sticky), 1);
        check("bubble_cnt", int'(err_cnt), CNT_ON ? 1 : 0);

        // Row complement mismatch.
        drive({16'hFFF0, 16'h0003, 16'hFFFF, 16'h0000}, 32'h0);
        in_vld = 0;
        step();
        check("compl_err", int'(code_err), 1);
        check("compl_cap", int'(num_cap), 32);

        // row_p all-ones: illegal and saturated.
        drive({16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000}, 32'h0);
        in_vld = 0;
        step();
        check("sat_cap", int'(num_cap), 255);
        check("sat_err", int'(code_err), 1);

        // Three identical back-to-back inputs.
        nv = 0; nc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) drive(legal_m(37), 32'h0);
            else begin in_vld = 0; step(); end
            nv += int'(out_vld); nc += int'(out_chg);
        end
        check("b2b_vld_cnt", nv, 3);
        check("b2b_chg_cnt", nc, 1);

        // Error counter saturation and clear racing a new error.
        err_clr = 1; step(); err_clr = 0;
        for (int i = 0; i < 260; i++) drive({16'hFFFF, 16'h0000, ~16'h0005, 16'h0005}, 32'h0);
        check("errcnt_sat", int'(err_cnt), CNT_ON ? 255 : 0);
        err_clr = 1;
        drive({16'hFFFF, 16'h0000, ~16'h0005, 16'h0005}, 32'h0);
        err_clr = 0;
        check("errclr_cnt", int'(err_cnt), CNT_ON ? 1 : 0);
        check("errclr_sticky", int'(err_sticky), 1);
        in_vld = 0; step(); step();

        // Enable dropped with a result in flight.
        drive(legal_m(100), 32'h1);
        csr_dec_en = 0;
        drive(legal_m(200), 32'h1);
        check("en_off_vld", int'(out_vld), 0);
        csr_dec_en = 1; in_vld = 0;
        step(); step();
        check("en_lost_vld", int'(out_vld), 0);

        // Reset one cycle after acceptance.
        drive(legal_m(50), 32'h7);
        dec_rst = 1;
        drive(legal_m(60), 32'h7);
        check("rstmid_vld", int'(out_vld), 0);
        check("rstmid_cap", int'(num_cap), 0);
        dec_rst = 0; in_vld = 0;
        step();
        check("rstmid_vld1", int'(out_vld), 0);
        step();
        check("rstmid_vld2", int'(out_vld), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int k;
            csr_dec_en = ($urandom % 8) != 0;
            in_vld     = ($urandom % 4) != 0;
            err_clr    = ($urandom % 16) == 0;
            dec_rst    = ($urandom % 200) == 0;
            k = int'($urandom_range(0, 32));
            word = {32'((64'd1 << k) - 64'd1), legal_m(int'($urandom_range(0, 255)))};
            if (($urandom % 4) == 0) word[$urandom_range(0, 95)] ^= 1'b1;
            band_thrm = word[95:64];
            mtrx_thrm = word[63:0];
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/thrm_dec.md
THRM_DEC -- requirements
Module: thrm_dec

Interface
REQ-001 Parameter: MTRX_W, 16, width of each matrix thermometer field (col_on, col_off, row_p, row_n).
REQ-002 Parameter: BAND_W, 32, width of band thermometer.
REQ-003 dec_clk  in  1  single clock; one clock, all logic on rising edge.
REQ-004 dec_rst  in  1  reset, synchronous, active-high.
REQ-005 csr_dec_en  in  1  block enable; 0 = hold pipeline, no captures.
REQ-006 in_vld  in  1  mtrx_thrm/band_thrm valid this cycle.
REQ-007 mtrx_thrm  in  64  [15:0] col_on, [31:16] col_off, [47:32] row_p, [63:48] row_n.
REQ-008 band_thrm  in  32  band thermometer, LSB-filled.
REQ-009 err_clr  in  1  clears err_cnt and err_sticky.
REQ-010 out_vld  out  1  num_cap/num_band/code_err valid.
REQ-011 num_cap  out  8  decoded matrix capacitor count.
REQ-012 num_band  out  6  decoded band count, 0..32.
REQ-013 code_err  out  1  current output came from an illegal code.
REQ-014 out_chg  out  1  one-cycle pulse: valid output differs from previous valid output.
REQ-015 err_sticky  out  1  set on any code_err, held until err_clr/reset.
REQ-016 err_cnt  out  8  saturating count of illegal codes (see Configuration).

Function
REQ-017 Thermometer legal = bits [k-1:0] set, all higher bits clear, k = popcount (k=0 legal).
REQ-018 num_cap = 16*popcount(row_p) + popcount(col_on), computed in 9 bits, saturated to 255.
REQ-019 num_band = popcount(band_thrm).
REQ-020 code_err = 1 if any of: row_p, col_on or band_thrm not thermometer; row_n != ~row_p; col_off != ~col_on; row_p == all-ones.
REQ-021 Counts use popcount even when code_err=1 (bubbles counted, not truncated).
REQ-022 Pipeline: stage 1 captures inputs when csr_dec_en && in_vld; stage 2 registers decoded results; out_vld asserted exactly 2 cycles after accepted in_vld.
REQ-023 Full throughput: one accepted input per cycle, no backpressure.
REQ-024 csr_dec_en=0: no new capture, stage valids clear next cycle, out_vld=0, data outputs hold last value.
REQ-025 out_chg = out_vld && (num_cap or num_band differs from last valid output); first valid output after reset counts as change.
REQ-026 err_sticky set on cycle code_err && out_vld; err_clr same cycle as new error: set wins.
REQ-027 err_clr same cycle as counted error: err_cnt becomes 1.

Reset
REQ-028 dec_rst=1 at clock edge: all outputs 0, both pipeline stages invalid, previous-value register 0 with "no previous" flag set.
REQ-029 Reset mid-stream discards in-flight data; no out_vld for inputs accepted in the 2 cycles before reset.

Configuration
REQ-030 Macro THRM_DEC_ERR_CNT_EN defined: err_cnt increments on each out_vld && code_err, saturates at 255, cleared by err_clr.
REQ-031 Macro undefined: err_cnt tied to 0, counter logic absent; err_sticky unaffected.

Structure
REQ-032 Shared package thrm_pkg: MTRX_W, BAND_W, field offsets COL_ON_LSB/COL_OFF_LSB/ROW_P_LSB/ROW_N_LSB, typedef of the 64-bit matrix struct.
REQ-033 One sub-module thrm_chk (parameterised width): popcount + thermometer-legal flag; instantiated for row_p, col_on, band_thrm.

Verification
REQ-034 Legal sweep: for s in 0..255 drive row_p=(1<<(s/16))-1, row_n=~row_p, col_on=(1<<(s%16))-1, col_off=~col_on, band=(1<<10)-1 -> num_cap=s, num_band=10, code_err=0, out_vld 2 cycles later.
REQ-035 Bubble: col_on=16'h0005, others legal for 0 -> code_err=1, num_cap=2, err_sticky=1, err_cnt=1 (macro on) / 0 (off).
REQ-036 Complement error: row_p=16'h0003, row_n=16'hFFF0 -> code_err=1, num_cap=32.
REQ-037 Back-to-back identical inputs (value 37 x3) -> out_vld 3 cycles, out_chg only on first.
REQ-038 255 illegal codes then 5 more, macro on -> err_cnt=255; err_clr with simultaneous error -> err_cnt=1, err_sticky=1.
REQ-039 dec_rst one cycle after accepted in_vld -> no out_vld for it, all outputs 0.
